// File: rtl/gpio_in_conditioner.sv
// Pad input conditioner: 2-flop sync, prescaled debounce, edge strobes, sticky pending flags, irq.
// Latency 3+thresh edges at presc 0 (3 in bypass); no backpressure, every input is sampled each cycle.
module gpio_in_conditioner #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 4,
    parameter int PRE_W = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    input  logic [WIDTH-1:0] pin_i,
    input  logic             bypass_i,
    input  logic [PRE_W-1:0] presc_i,
    input  logic [CNT_W-1:0] thresh_i,
    input  logic [WIDTH-1:0] rise_en_i,
    input  logic [WIDTH-1:0] fall_en_i,
    input  logic [WIDTH-1:0] pend_clr_i,
    output logic [WIDTH-1:0] gpi_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o,
    output logic [WIDTH-1:0] pend_o,
    output logic             irq_o
);

    logic [WIDTH-1:0]            sync1;
    logic [WIDTH-1:0]            sync2;
    logic [WIDTH-1:0]            stable;
    logic [WIDTH-1:0]            stable_nxt;
    logic [WIDTH-1:0]            prev;
    logic [WIDTH-1:0]            pend;
    logic [WIDTH-1:0]            pend_nxt;
    logic [WIDTH-1:0][CNT_W-1:0] cnt;
    logic [WIDTH-1:0][CNT_W-1:0] cnt_nxt;
    logic [PRE_W-1:0]            pc;
    logic                        tick;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= pin_i;
            sync2 <= sync1;
        end
    end

    // >= rather than == so that lowering presc_i mid-count wraps immediately
    assign tick = (pc >= presc_i);

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            pc <= '0;
        end else if (tick) begin
            pc <= '0;
        end else begin
            pc <= pc + PRE_W'(1);
        end
    end

    always_comb begin
        stable_nxt = stable;
        cnt_nxt    = cnt;
        for (int i = 0; i < WIDTH; i++) begin
            if (bypass_i) begin
                stable_nxt[i] = sync2[i];
                cnt_nxt[i]    = '0;
            end else if (sync2[i] == stable[i]) begin
                cnt_nxt[i] = '0;
            end else if (tick) begin
                if (cnt[i] == thresh_i) begin
                    stable_nxt[i] = sync2[i];
                    cnt_nxt[i]    = '0;
                end else begin
                    cnt_nxt[i] = cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            stable <= '0;
            prev   <= '0;
            cnt    <= '0;
        end else begin
            stable <= stable_nxt;
            prev   <= stable;
            cnt    <= cnt_nxt;
        end
    end

    assign rise_o = stable & ~prev;
    assign fall_o = ~stable & prev;

    // A set in the same cycle as a clear leaves the flag set
    assign pend_nxt = (pend & ~pend_clr_i) | (rise_o & rise_en_i) | (fall_o & fall_en_i);

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            pend <= '0;
        end else begin
            pend <= pend_nxt;
        end
    end

    assign gpi_o  = stable;
    assign pend_o = pend;
    assign irq_o  = |pend;

endmodule

// File: tb/tb_gpio_in_conditioner.sv
// Directed bench for gpio_in_conditioner; inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_gpio_in_conditioner;

    logic        clk;
    logic        rst_n;
    logic [31:0] pin;
    logic        bypass;
    logic [15:0] presc;
    logic [3:0]  thresh;
    logic [31:0] rise_en;
    logic [31:0] fall_en;
    logic [31:0] pend_clr;
    logic [31:0] gpi;
    logic [31:0] rise;
    logic [31:0] fall;
    logic [31:0] pend;
    logic        irq;

    int n_assert = 0;
    int n_fail   = 0;

    gpio_in_conditioner #(.WIDTH(32), .CNT_W(4), .PRE_W(16)) dut (
        .wb_clk_i   (clk),
        .wb_rst_ni  (rst_n),
        .pin_i      (pin),
        .bypass_i   (bypass),
        .presc_i    (presc),
        .thresh_i   (thresh),
        .rise_en_i  (rise_en),
        .fall_en_i  (fall_en),
        .pend_clr_i (pend_clr),
        .gpi_o      (gpi),
        .rise_o     (rise),
        .fall_o     (fall),
        .pend_o     (pend),
        .irq_o      (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [31:0] seen;
        logic [31:0] seen_gpi;
        int          lat;
        int          w;

        rst_n    = 1'b0;
        pin      = 32'hFFFF_FFFF;
        bypass   = 1'b0;
        presc    = 16'd0;
        thresh   = 4'd2;
        rise_en  = 32'hFFFF_FFFF;
        fall_en  = 32'h0;
        pend_clr = 32'h0;
        #1;
        step(3);
        check("rst_gpi",  gpi,  32'h0);
        check("rst_rise", rise, 32'h0);
        check("rst_fall", fall, 32'h0);
        check("rst_pend", pend, 32'h0);
        check("rst_irq",  {31'b0, irq}, 32'h0);

        // pins high through reset qualify 5 edges after release
        rst_n = 1'b1;
        step(4);
        check("rel_gpi_early", gpi, 32'h0);
        step(1);
        check("rel_gpi",  gpi,  32'hFFFF_FFFF);
        check("rel_rise", rise, 32'hFFFF_FFFF);
        check("rel_irq_lag", {31'b0, irq}, 32'h0);
        step(1);
        check("rel_rise_end", rise, 32'h0);
        check("rel_pend", pend, 32'hFFFF_FFFF);
        check("rel_irq",  {31'b0, irq}, 32'h1);
        pend_clr = 32'hFFFF_FFFF;
        step(1);
        pend_clr = 32'h0;
        check("clr_all_pend", pend, 32'h0);
        check("clr_all_irq",  {31'b0, irq}, 32'h0);

        // fall with fall_en off: strobe, no pending
        pin = 32'h0;
        step(4);
        check("fall_gpi_early", gpi, 32'hFFFF_FFFF);
        step(1);
        check("fall_gpi",  gpi,  32'h0);
        check("fall_strb", fall, 32'hFFFF_FFFF);
        step(1);
        check("fall_strb_end", fall, 32'h0);
        check("fall_no_pend",  pend, 32'h0);

        // short glitch on pin 5 rejected
        thresh = 4'd3;
        pin = 32'h20;
        step(3);
        pin = 32'h0;
        seen = 32'h0;
        seen_gpi = 32'h0;
        for (int k = 0; k < 10; k++) begin
            step(1);
            seen     = seen | rise;
            seen_gpi = seen_gpi | gpi;
        end
        check("glitch_gpi",  seen_gpi, 32'h0);
        check("glitch_rise", seen, 32'h0);
        check("glitch_pend", pend, 32'h0);

        // held change qualifies exactly 6 edges later
        pin = 32'h20;
        step(5);
        check("hold_gpi_early", gpi, 32'h0);
        step(1);
        check("hold_gpi",  gpi,  32'h20);
        check("hold_rise", rise, 32'h20);
        step(1);
        check("hold_rise_end", rise, 32'h0);
        check("hold_pend", pend, 32'h20);
        check("hold_irq",  {31'b0, irq}, 32'h1);
        pend_clr = 32'hFFFF_FFFF;
        step(1);
        pend_clr = 32'h0;

        // prescaled latency window
        presc  = 16'd9;
        thresh = 4'd1;
        pin    = 32'h21;
        lat    = 0;
        while (lat < 40 && gpi[0] !== 1'b1) begin
            step(1);
            lat++;
        end
        check("presc_lat_in_range", {31'b0, (lat >= 13 && lat <= 23)}, 32'h1);
        check("presc_rise", rise, 32'h1);

        // lower presc while pc = 7: wrap on the next edge, then period 3
        w = 0;
        while (w < 20 && dut.pc !== 16'd7) begin
            step(1);
            w++;
        end
        check("pc_reached_7", {31'b0, (w < 20)}, 32'h1);
        presc = 16'd2;
        #1;
        check("presc_drop_tick", {31'b0, dut.tick}, 32'h1);
        for (int k = 0; k < 6; k++) begin
            step(1);
            check("presc_period3", {31'b0, dut.tick}, {31'b0, (k % 3 == 2)});
        end

        // set beats clear on pin 7
        presc    = 16'd0;
        thresh   = 4'd0;
        rise_en  = 32'h0;
        fall_en  = 32'h80;
        pend_clr = 32'hFFFF_FFFF;
        step(1);
        pend_clr = 32'h0;
        pin = 32'hA1;
        step(3);
        check("p7_rise", rise, 32'h80);
        step(1);
        check("p7_rise_masked", pend, 32'h0);
        pin = 32'h21;
        step(3);
        check("p7_fall", fall, 32'h80);
        pend_clr = 32'h80;
        step(1);
        check("set_beats_clr_pend", pend, 32'h80);
        check("set_beats_clr_irq",  {31'b0, irq}, 32'h1);
        step(1);
        pend_clr = 32'h0;
        check("clr_alone_pend", pend, 32'h0);
        check("clr_alone_irq",  {31'b0, irq}, 32'h0);

        // bypass: toggling with steady pins gives no strobes
        bypass = 1'b1;
        seen = 32'h0;
        for (int k = 0; k < 4; k++) begin
            step(1);
            seen = seen | rise | fall;
        end
        check("byp_on_quiet", seen, 32'h0);
        check("byp_on_gpi",   gpi,  32'h21);

        rise_en = 32'h8000_0000;
        pin = 32'h8000_0021;
        step(2);
        check("byp_gpi_early", gpi, 32'h21);
        step(1);
        check("byp_gpi",  gpi,  32'h8000_0021);
        check("byp_rise", rise, 32'h8000_0000);
        step(1);
        check("byp_pend", pend, 32'h8000_0000);
        check("byp_irq",  {31'b0, irq}, 32'h1);
        pend_clr = 32'hFFFF_FFFF;
        step(1);
        pend_clr = 32'h0;

        rise_en = 32'h0;
        pin = 32'h21;
        step(3);
        check("byp_fall", fall, 32'h8000_0000);
        step(1);
        check("byp_fall_no_pend", pend, 32'h0);
        pin = 32'h8000_0021;
        step(3);
        check("byp_rise2", rise, 32'h8000_0000);
        step(1);
        check("byp_rise_masked", pend, 32'h0);

        bypass = 1'b0;
        seen = 32'h0;
        for (int k = 0; k < 4; k++) begin
            step(1);
            seen = seen | rise | fall;
        end
        check("byp_off_quiet", seen, 32'h0);
        check("byp_off_gpi",   gpi,  32'h8000_0021);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
